sound_cmd_mailbox: RTL and testbench



---
 rtl/sound_cmd_mailbox_if.sv | 50 +++++
 rtl/sound_cmd_mailbox.sv | 134 +++++++++++++
 tb/tb_sound_cmd_mailbox.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sound_cmd_mailbox_if.sv
// Main-to-sound command mailbox bus: main CPU write side, sound CPU read side.
// Carries mbox_overflow only when SND_MAILBOX_OVERFLOW_EN is defined.
interface sound_cmd_mailbox_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          cs_sounddata;
  logic [DW-1:0] wr_data;
  logic          irq_trigger;
  logic          cs_snd_rd;
  logic          irq_ack;
  logic [DW-1:0] rd_data;
  logic          snd_irq_n;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
`ifdef SND_MAILBOX_OVERFLOW_EN
  logic          mbox_overflow;

  modport master (
    output cs_sounddata, wr_data, irq_trigger,
    output cs_snd_rd, irq_ack,
    input  rd_data, snd_irq_n, fifo_empty,
    input  fifo_full, fifo_count, mbox_overflow
  );

  modport slave (
    input  cs_sounddata, wr_data, irq_trigger,
    input  cs_snd_rd, irq_ack,
    output rd_data, snd_irq_n, fifo_empty,
    output fifo_full, fifo_count, mbox_overflow
  );
`else
  modport master (
    output cs_sounddata, wr_data, irq_trigger,
    output cs_snd_rd, irq_ack,
    input  rd_data, snd_irq_n, fifo_empty,
    input  fifo_full, fifo_count
  );

  modport slave (
    input  cs_sounddata, wr_data, irq_trigger,
    input  cs_snd_rd, irq_ack,
    output rd_data, snd_irq_n, fifo_empty,
    output fifo_full, fifo_count
  );
`endif
endinterface

// File: rtl/sound_cmd_mailbox.sv
// Main-to-sound CPU command FIFO with IRQ; DEPTH=1 is the legacy latch.
// Optional sticky drop flag enabled by SND_MAILBOX_OVERFLOW_EN.
module sound_cmd_mailbox #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int IRQ_AUTO = 0
) (
  input logic clk_49m,
  input logic reset,
  sound_cmd_mailbox_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit LATCH = (DEPTH == 1);
  localparam bit AUTO = (IRQ_AUTO != 0);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          irq_n_q, irq_n_d;
  logic          cs_q, cs_d;
  logic          trig_q, trig_d;
  logic          rdsel_q, rdsel_d;
  logic          ack_q, ack_d;
  logic [2:0]    arm_q, arm_d;
  logic          ovf_q, ovf_d;

  logic full;
  logic push_ev, pop_ev, trig_ev, ack_ev;
  logic push_ok, drop;

  // Rising edges count only once the input has been seen low after reset.
  assign push_ev = bus.cs_sounddata & ~cs_q & arm_q[0];
  assign trig_ev = bus.irq_trigger & ~trig_q & arm_q[1];
  assign ack_ev  = bus.irq_ack & ~ack_q & arm_q[2];
  assign pop_ev  = ~bus.cs_snd_rd & rdsel_q & (cnt_q != '0);

  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push_ev & (LATCH | ~full | pop_ev);
  assign drop    = push_ev & ~push_ok;

  always_comb begin
    cs_d    = bus.cs_sounddata;
    trig_d  = bus.irq_trigger;
    rdsel_d = bus.cs_snd_rd;
    ack_d   = bus.irq_ack;
    arm_d   = arm_q | ~{bus.irq_ack, bus.irq_trigger, bus.cs_sounddata};
  end

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wp_q] = bus.wr_data;
      if (!LATCH) wp_d = wp_q + AW'(1);
    end
    if (pop_ev && !LATCH) rp_d = rp_q + AW'(1);
    if (LATCH) begin
      if (push_ok)     cnt_d = CW'(1);
      else if (pop_ev) cnt_d = '0;
    end else begin
      unique case ({push_ok, pop_ev})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Head is reloaded from registered state, so rd_data trails a push by one clock.
  always_comb begin
    rd_d = rd_q;
    if (cnt_q != '0) rd_d = mem_q[rp_q];
  end

  always_comb begin
    irq_n_d = irq_n_q;
    if (trig_ev || (AUTO && push_ok)) irq_n_d = 1'b0;
    else if (ack_ev)                  irq_n_d = 1'b1;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)                           ovf_d = 1'b1;
    else if (ack_ev && cnt_q == '0)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      irq_n_q <= 1'b1;
      cs_q    <= 1'b0;
      trig_q  <= 1'b0;
      rdsel_q <= 1'b0;
      ack_q   <= 1'b0;
      arm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      irq_n_q <= irq_n_d;
      cs_q    <= cs_d;
      trig_q  <= trig_d;
      rdsel_q <= rdsel_d;
      ack_q   <= ack_d;
      arm_q   <= arm_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.snd_irq_n  = irq_n_q;
  assign bus.fifo_count = cnt_q;
  assign bus.fifo_empty = (cnt_q == '0);
  assign bus.fifo_full  = full;
`ifdef SND_MAILBOX_OVERFLOW_EN
  assign bus.mbox_overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sound_cmd_mailbox.sv
// Scoreboard bench: DEPTH=4 queue (dut a) and DEPTH=1 auto-IRQ latch (dut b).
// Overflow checks compile in with SND_MAILBOX_OVERFLOW_EN.
module tb_sound_cmd_mailbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;

  sound_cmd_mailbox_if #(.DW(8), .DEPTH(4)) a_if ();
  sound_cmd_mailbox_if #(.DW(8), .DEPTH(1)) b_if ();

  sound_cmd_mailbox #(.DW(8), .DEPTH(4), .IRQ_AUTO(0)) u_a (
    .clk_49m(clk),
    .reset  (rst),
    .bus    (a_if.slave)
  );

  sound_cmd_mailbox #(.DW(8), .DEPTH(1), .IRQ_AUTO(1)) u_b (
    .clk_49m(clk),
    .reset  (rst),
    .bus    (b_if.slave)
  );

  logic [7:0] sb_a [$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] sb_b [$];
  logic       ovf_a = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    a_if.wr_data      = d;
    a_if.cs_sounddata = 1'b1;
    if (sb_a.size() < 4) sb_a.push_back(d);
    else ovf_a = 1'b1;
    @(negedge clk);
    a_if.cs_sounddata = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_a(input string tag);
    logic [7:0] exp;
    exp = (sb_a.size() != 0) ? sb_a[0] : last_a;
    check(tag, {24'h0, a_if.rd_data}, {24'h0, exp});
    a_if.cs_snd_rd = 1'b1;
    @(negedge clk);
    a_if.cs_snd_rd = 1'b0;
    if (sb_a.size() != 0) last_a = sb_a.pop_front();
    @(negedge clk);
    @(negedge clk);
    check({tag, "_cnt"}, 32'(a_if.fifo_count), 32'(sb_a.size()));
  endtask

  task automatic push_b(input logic [7:0] d);
    b_if.wr_data      = d;
    b_if.cs_sounddata = 1'b1;
    sb_b.delete();
    sb_b.push_back(d);
    @(negedge clk);
    b_if.cs_sounddata = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rd"}, {24'h0, a_if.rd_data}, 32'h0);
    check({tag, "_irqn"}, 32'(a_if.snd_irq_n), 32'h1);
    check({tag, "_empty"}, 32'(a_if.fifo_empty), 32'h1);
    check({tag, "_full"}, 32'(a_if.fifo_full), 32'h0);
    check({tag, "_cnt"}, 32'(a_if.fifo_count), 32'h0);
  endtask

  initial begin
    a_if.cs_sounddata = 1'b0;
    a_if.wr_data      = 8'h00;
    a_if.irq_trigger  = 1'b0;
    a_if.cs_snd_rd    = 1'b0;
    a_if.irq_ack      = 1'b0;
    b_if.cs_sounddata = 1'b0;
    b_if.wr_data      = 8'h00;
    b_if.irq_trigger  = 1'b0;
    b_if.cs_snd_rd    = 1'b0;
    b_if.irq_ack      = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_a("rst");
`ifdef SND_MAILBOX_OVERFLOW_EN
    check("rst_ovf", 32'(a_if.mbox_overflow), 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: long cs hold pushes once
    a_if.wr_data      = 8'h3C;
    a_if.cs_sounddata = 1'b1;
    sb_a.push_back(8'h3C);
    @(negedge clk);
    @(negedge clk);
    check("t1_rd", {24'h0, a_if.rd_data}, 32'h3C);
    check("t1_cnt", 32'(a_if.fifo_count), 32'h1);
    repeat (4) @(negedge clk);
    a_if.cs_sounddata = 1'b0;
    check("t1_cnt_hold", 32'(a_if.fifo_count), 32'h1);
    check("t1_irqn", 32'(a_if.snd_irq_n), 32'h1);
    read_a("t1_read");

    // 2: overflow drop and drain past empty
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    push_a(8'h55);
    check("t2_full", 32'(a_if.fifo_full), 32'h1);
    check("t2_cnt", 32'(a_if.fifo_count), 32'h4);
`ifdef SND_MAILBOX_OVERFLOW_EN
    check("t2_ovf", 32'(a_if.mbox_overflow), 32'(ovf_a));
`endif
    for (int i = 0; i < 5; i++) read_a("t2_read");
    check("t2_rd_hold", {24'h0, a_if.rd_data}, 32'h44);
    check("t2_empty", 32'(a_if.fifo_empty), 32'h1);

    // 3: simultaneous push and pop while full
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    check("t3_full", 32'(a_if.fifo_full), 32'h1);
    check("t3_head", {24'h0, a_if.rd_data}, {24'h0, sb_a[0]});
    a_if.cs_snd_rd = 1'b1;
    @(negedge clk);
    a_if.cs_snd_rd    = 1'b0;
    a_if.wr_data      = 8'h66;
    a_if.cs_sounddata = 1'b1;
    last_a = sb_a.pop_front();
    sb_a.push_back(8'h66);
    @(negedge clk);
    a_if.cs_sounddata = 1'b0;
    @(negedge clk);
    check("t3_cnt", 32'(a_if.fifo_count), 32'h4);
    for (int i = 0; i < 4; i++) read_a("t3_read");

    // 4: IRQ set/clear, set wins on collision
    a_if.irq_trigger = 1'b1;
    @(negedge clk);
    check("t4_irq_set", 32'(a_if.snd_irq_n), 32'h0);
    a_if.irq_trigger = 1'b0;
    @(negedge clk);
    a_if.irq_trigger = 1'b1;
    a_if.irq_ack     = 1'b1;
    @(negedge clk);
    check("t4_irq_both", 32'(a_if.snd_irq_n), 32'h0);
    a_if.irq_trigger = 1'b0;
    a_if.irq_ack     = 1'b0;
    @(negedge clk);
    a_if.irq_ack = 1'b1;
    @(negedge clk);
    check("t4_irq_clr", 32'(a_if.snd_irq_n), 32'h1);
    a_if.irq_ack = 1'b0;
    ovf_a = 1'b0;
    @(negedge clk);
`ifdef SND_MAILBOX_OVERFLOW_EN
    check("t4_ovf_clr", 32'(a_if.mbox_overflow), 32'(ovf_a));
`endif

    // 5: legacy latch with auto IRQ
    push_b(8'hA5);
    check("t5_irqn", 32'(b_if.snd_irq_n), 32'h0);
    check("t5_rd1", {24'h0, b_if.rd_data}, {24'h0, sb_b[0]});
    push_b(8'h5A);
    check("t5_rd2", {24'h0, b_if.rd_data}, {24'h0, sb_b[0]});
    check("t5_cnt", 32'(b_if.fifo_count), 32'h1);
    check("t5_full", 32'(b_if.fifo_full), 32'h1);
`ifdef SND_MAILBOX_OVERFLOW_EN
    check("t5_ovf", 32'(b_if.mbox_overflow), 32'h0);
`endif
    b_if.cs_snd_rd = 1'b1;
    @(negedge clk);
    b_if.cs_snd_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_pop_cnt", 32'(b_if.fifo_count), 32'h0);
    check("t5_pop_rd", {24'h0, b_if.rd_data}, {24'h0, sb_b[0]});

    // 6: async reset mid-queue
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    a_if.irq_trigger = 1'b1;
    @(negedge clk);
    a_if.irq_trigger = 1'b0;
    check("t6_pre_cnt", 32'(a_if.fifo_count), 32'h3);
    check("t6_pre_irqn", 32'(a_if.snd_irq_n), 32'h0);
    rst = 1'b1;
    #1;
    check_reset_a("t6_async");
    check("t6_b_cnt", 32'(b_if.fifo_count), 32'h0);
    sb_a.delete();
    last_a            = 8'h00;
    a_if.wr_data      = 8'h77;
    a_if.cs_sounddata = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_nopush_cnt", 32'(a_if.fifo_count), 32'h0);
    check("t6_nopush_empty", 32'(a_if.fifo_empty), 32'h1);
    a_if.cs_sounddata = 1'b0;
    @(negedge clk);
    push_a(8'h88);
    check("t6_recover_cnt", 32'(a_if.fifo_count), 32'h1);
    read_a("t6_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
